clk_gate_ctrl: RTL and testbench
================================

Name: clk_gate_ctrl

Overview:
Enable-side controller for the team's clock gate cell: it produces the registered enable that drives the gate's enable input. Consumers raise a level request and receive an acknowledge once the gated clock is running and settled. The controller auto-gates the clock after a programmable idle period and enforces minimum on/off dwell times. It sits in Time_Manager, one instance per gated clock domain.

Parameters:
WAKE_CYCLES, 2, cycles between enable rising and ACK rising; legal range 1..2^CNT_W-1
IDLE_CYCLES, 8, consecutive cycles of REQ=0 and FORCE_ON=0 in ON before gating; legal range 1..2^CNT_W-1
MIN_OFF, 3, minimum cycles the enable stays low once dropped; legal range 1..2^CNT_W-1
CNT_W, 8, width of the shared dwell counter

Ports:
CLK_IN  input  1  free-running source clock, also the clock fed to the gate cell
RST  input  1  synchronous, active-high reset
REQ  input  1  level request from consumer(s), already OR-ed upstream
FORCE_ON  input  1  debug/override; when high, auto-gating is inhibited
CLK_ENO  output  1  registered enable to gate cell CLK_ENI; changes only on CLK_IN rising edge
ACK  output  1  gated clock is running and settled
STATE_O  output  2  current state encoding, for debug

Behaviour:
- Reset (RST=1 at a rising edge): state OFF, counter 0, CLK_ENO=0, ACK=0, STATE_O=0. Reset mid-operation drops the enable on that same edge; MIN_OFF is not enforced after reset.
- All outputs are Moore outputs decoded from registered state; no combinational path from inputs to outputs.
- Wake condition W = REQ | FORCE_ON.
- State encodings: OFF=0, WAKE=1, ON=2, COOL=3.
- OFF: CLK_ENO=0, ACK=0. If W=1 at edge k, go to WAKE and load counter=WAKE_CYCLES-1. CLK_ENO is high after edge k.
- WAKE: CLK_ENO=1, ACK=0. Counter decrements each cycle. At counter=0, go to ON; ACK is high after edge k+WAKE_CYCLES. Deasserting REQ during WAKE does not abort the sequence: WAKE always completes.
- ON: CLK_ENO=1, ACK=1. Counter counts consecutive cycles with W=0 and clears on any cycle with W=1.
  - When the count reaches IDLE_CYCLES (the edge that samples the IDLE_CYCLES-th consecutive W=0), go to COOL and load counter=MIN_OFF-1.
  - Example: REQ falls before edge j, IDLE_CYCLES=4 → CLK_ENO and ACK are low after edge j+3.
- COOL: CLK_ENO=0, ACK=0. Counter decrements, and W is ignored while counting. At counter=0: if W=1, go directly to WAKE (load WAKE_CYCLES-1); otherwise go to OFF.
- Simultaneous events:
  - W rising on the same edge the idle count expires: gating wins (go to COOL), then re-wake after MIN_OFF.
  - FORCE_ON behaves identically to REQ for wake, but is also counted when blocking gating.
- Counter arithmetic is unsigned CNT_W bits with no wrap. The ON idle count saturates at IDLE_CYCLES.

Optional Feature:
Macro CLK_GATE_STATS_EN.
- Defined:
  - Adds output GATED_CNT (16 bits): a saturating count of cycles with CLK_ENO=0, holding at 16'hFFFF.
  - Adds input STATS_CLR (1 bit): synchronous clear of the count; clear takes priority over increment.
  - RST clears the count.
- Undefined: neither port exists and no counter logic is generated. Core behaviour is identical in both builds.

Decomposition:
- Package clk_gate_pkg: 2-bit state typedef with the OFF/WAKE/ON/COOL constants, and the default timing constants.
- Optional sub-module: clk_gate_stats, containing the saturating 16-bit counter, instantiated only under CLK_GATE_STATS_EN.
- The FSM and dwell counter stay in a single module.

Test Plan:
All scenarios use parameters WAKE_CYCLES=2, IDLE_CYCLES=4, MIN_OFF=3.
1. Reset release with REQ=0 for 10 cycles → CLK_ENO=0, ACK=0, STATE_O=0 throughout.
2. REQ rises, sampled at edge k → CLK_ENO=1 after edge k; ACK=1 after edge k+2; STATE_O goes 1 then 2.
3. In ON, REQ falls, first sampled low at edge j → CLK_ENO and ACK stay 1 through edge j+2 and are 0 after edge j+3. Additionally, a 1-cycle REQ pulse at j+2 restarts the idle count: gating then occurs 4 cycles after the pulse.
4. Gating occurs; REQ re-rises on the next cycle → CLK_ENO holds 0 for exactly 3 cycles (COOL), then goes to WAKE; ACK returns 2 cycles later.
5. FORCE_ON=1 with REQ=0 for 50 cycles → CLK_ENO=1 and ACK=1 continuously after wake. Dropping FORCE_ON → gating after 4 cycles.
6. RST pulsed while in WAKE and while in ON → CLK_ENO=0 and ACK=0 on the next edge, state OFF. With CLK_GATE_STATS_EN defined, GATED_CNT equals the number of CLK_ENO=0 cycles observed by the bench, and STATS_CLR zeroes it.

Source files
------------

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg
// Shared definitions for the clock gate enable controller.
//  - state_t     : 2-bit FSM state type, with the OFF/WAKE/ON/COOL encodings
//  - DEF_*       : default timing and counter-width constants
package clk_gate_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_OFF  = 2'd0;
  localparam state_t ST_WAKE = 2'd1;
  localparam state_t ST_ON   = 2'd2;
  localparam state_t ST_COOL = 2'd3;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int DEF_MIN_OFF     = 3;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/clk_gate_stats.sv
// clk_gate_stats
// Saturating 16-bit count of cycles during which the gate enable is low.
// The count holds at 16'hFFFF. A clear takes priority over an increment.
// Ports:
//   clk      : source clock
//   rst      : synchronous active-high reset, clears the count
//   clr      : synchronous clear of the count
//   gate_off : high while the gate enable is low
//   count    : current count
module clk_gate_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        gate_off,
  output logic [15:0] count
);

  // Count gated cycles and stick at full scale rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 16'd0;
    end else if (gate_off && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
// Enable-side controller for a clock gate cell. A consumer raises REQ (or
// FORCE_ON); the controller raises CLK_ENO, waits WAKE_CYCLES for the gated
// clock to settle and then raises ACK. After IDLE_CYCLES consecutive idle
// cycles in ON it drops the enable and holds it low for at least MIN_OFF.
// Ports:
//   CLK_IN    : free-running source clock
//   RST       : synchronous active-high reset
//   REQ       : level request from consumers
//   FORCE_ON  : override, wakes like REQ and blocks auto-gating
//   CLK_ENO   : registered enable to the gate cell
//   ACK       : gated clock is running and settled
//   STATE_O   : current FSM state, for debug
//   STATS_CLR : (CLK_GATE_STATS_EN only) clears GATED_CNT
//   GATED_CNT : (CLK_GATE_STATS_EN only) saturating count of gated cycles
// Optional feature macro: CLK_GATE_STATS_EN
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int MIN_OFF     = DEF_MIN_OFF,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        REQ,
  input  logic        FORCE_ON,
`ifdef CLK_GATE_STATS_EN
  input  logic        STATS_CLR,
  output logic [15:0] GATED_CNT,
`endif
  output logic        CLK_ENO,
  output logic        ACK,
  output logic [1:0]  STATE_O
);

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(MIN_OFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             wake;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             eno_q;
  logic             ack_q;

  assign wake = REQ | FORCE_ON;

  // Next-state and dwell counter. The one counter serves as the wake
  // timer, the idle counter and the minimum-off timer depending on state.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_OFF: begin
        if (wake) begin
          next_state = ST_WAKE;
          next_cnt   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt == '0) begin
          next_state = ST_ON;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_ON: begin
        if (wake) begin
          next_cnt = '0;
        end else if (cnt >= IDLE_LAST) begin
          // This edge samples the final idle cycle, so gate now.
          next_state = ST_COOL;
          next_cnt   = OFF_LOAD;
        end else begin
          next_cnt = cnt + CNT_ONE;
        end
      end
      ST_COOL: begin
        // Requests are ignored until the minimum off time has elapsed.
        if (cnt != '0) begin
          next_cnt = cnt - CNT_ONE;
        end else if (wake) begin
          next_state = ST_WAKE;
          next_cnt   = WAKE_LOAD;
        end else begin
          next_state = ST_OFF;
        end
      end
      default: begin
        next_state = ST_OFF;
        next_cnt   = '0;
      end
    endcase
  end

  // State, counter and output flops. The enable and acknowledge are
  // registered from the next state so the gate cell sees a clean flop
  // output rather than a decode of the state bits.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state <= ST_OFF;
      cnt   <= '0;
      eno_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      eno_q <= (next_state == ST_WAKE) || (next_state == ST_ON);
      ack_q <= (next_state == ST_ON);
    end
  end

  assign CLK_ENO = eno_q;
  assign ACK     = ack_q;
  assign STATE_O = state;

`ifdef CLK_GATE_STATS_EN
  clk_gate_stats u_stats (
    .clk      (CLK_IN),
    .rst      (RST),
    .clr      (STATS_CLR),
    .gate_off (~eno_q),
    .count    (GATED_CNT)
  );
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
// Self-checking bench for clk_gate_ctrl with WAKE_CYCLES=2, IDLE_CYCLES=4,
// MIN_OFF=3. Each stimulus entry packs {RST, FORCE_ON, REQ} and the
// expected {CLK_ENO, ACK, STATE_O} after the following rising edge.
// Optional feature macro: CLK_GATE_STATS_EN
module tb_clk_gate_ctrl;

  logic        CLK_IN;
  logic        RST;
  logic        REQ;
  logic        FORCE_ON;
  logic        CLK_ENO;
  logic        ACK;
  logic [1:0]  STATE_O;
`ifdef CLK_GATE_STATS_EN
  logic        STATS_CLR;
  logic [15:0] GATED_CNT;
  logic [15:0] gated_model;
`endif

  int checks;
  int fails;
  logic [3:0] sb[$];
  logic [3:0] exp_v;
  logic [3:0] obs_v;

  localparam logic [2:0] N = 3'b000;
  localparam logic [2:0] Q = 3'b001;
  localparam logic [2:0] F = 3'b010;
  localparam logic [2:0] R = 3'b100;

  localparam logic [3:0] E_OFF  = 4'b0000;
  localparam logic [3:0] E_WAKE = 4'b1001;
  localparam logic [3:0] E_ON   = 4'b1110;
  localparam logic [3:0] E_COOL = 4'b0011;

  localparam logic [6:0] RESET_STIM [12] = '{
    {R, E_OFF}, {R, E_OFF}, {N, E_OFF}, {N, E_OFF}, {N, E_OFF}, {N, E_OFF},
    {N, E_OFF}, {N, E_OFF}, {N, E_OFF}, {N, E_OFF}, {N, E_OFF}, {N, E_OFF}};

  localparam logic [6:0] WAKE_STIM [4] = '{
    {Q, E_WAKE}, {Q, E_WAKE}, {Q, E_ON}, {Q, E_ON}};

  localparam logic [6:0] IDLE_STIM [20] = '{
    {N, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_COOL}, {N, E_COOL}, {N, E_COOL},
    {N, E_OFF}, {Q, E_WAKE}, {Q, E_WAKE}, {Q, E_ON}, {N, E_ON}, {N, E_ON},
    {Q, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_COOL}, {N, E_COOL},
    {N, E_COOL}, {N, E_OFF}};

  localparam logic [6:0] REWAKE_STIM [12] = '{
    {Q, E_WAKE}, {Q, E_WAKE}, {Q, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_ON},
    {N, E_COOL}, {Q, E_COOL}, {Q, E_COOL}, {Q, E_WAKE}, {Q, E_WAKE},
    {Q, E_ON}};

  localparam logic [6:0] FORCE_STIM [10] = '{
    {N, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_COOL}, {N, E_COOL}, {N, E_COOL},
    {N, E_OFF}, {F, E_WAKE}, {F, E_WAKE}, {F, E_ON}};

  localparam logic [6:0] RST_MID_STIM [14] = '{
    {Q, E_ON}, {R, E_OFF}, {Q, E_WAKE}, {R, E_OFF}, {Q, E_WAKE},
    {Q, E_WAKE}, {Q, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_ON}, {N, E_COOL},
    {N, E_COOL}, {N, E_COOL}, {N, E_OFF}};

  clk_gate_ctrl #(
    .WAKE_CYCLES (2),
    .IDLE_CYCLES (4),
    .MIN_OFF     (3),
    .CNT_W       (8)
  ) dut (
    .CLK_IN    (CLK_IN),
    .RST       (RST),
    .REQ       (REQ),
    .FORCE_ON  (FORCE_ON),
`ifdef CLK_GATE_STATS_EN
    .STATS_CLR (STATS_CLR),
    .GATED_CNT (GATED_CNT),
`endif
    .CLK_ENO   (CLK_ENO),
    .ACK       (ACK),
    .STATE_O   (STATE_O)
  );

  initial CLK_IN = 1'b0;
  always #5 CLK_IN = ~CLK_IN;

`ifdef CLK_GATE_STATS_EN
  // Bench-side tally of cycles the enable was seen low at each edge.
  initial gated_model = 16'd0;
  always @(posedge CLK_IN) begin
    if (RST || STATS_CLR) gated_model = 16'd0;
    else if (!CLK_ENO && gated_model != 16'hFFFF) gated_model = gated_model + 16'd1;
  end
`endif

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  // Drive one cycle of inputs, record what should follow the edge, clock.
  task automatic drive_cycle(input logic [6:0] s);
    {RST, FORCE_ON, REQ} = s[6:4];
    sb.push_back(s[3:0]);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < $size(RESET_STIM); i++) begin
      drive_cycle(RESET_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_reset cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_wake();
    for (int i = 0; i < $size(WAKE_STIM); i++) begin
      drive_cycle(WAKE_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_wake cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_idle_gating();
    for (int i = 0; i < $size(IDLE_STIM); i++) begin
      drive_cycle(IDLE_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_idle_gating cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < $size(REWAKE_STIM); i++) begin
      drive_cycle(REWAKE_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_back_to_back cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_force_on();
    for (int i = 0; i < 50; i++) begin
      drive_cycle({F, E_ON});
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_force_on hold cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
    for (int i = 0; i < $size(FORCE_STIM); i++) begin
      drive_cycle(FORCE_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_force_on release cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < $size(RST_MID_STIM); i++) begin
      drive_cycle(RST_MID_STIM[i]);
      exp_v = sb.pop_front();
      obs_v = {CLK_ENO, ACK, STATE_O};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("[TB] FAIL test_reset_mid cycle %0d: eno/ack/state got %b need %b", i, obs_v, exp_v);
      end
    end
  endtask

`ifdef CLK_GATE_STATS_EN
  task automatic test_stats();
    {RST, FORCE_ON, REQ} = 3'b000;
    checks++;
    if (GATED_CNT !== gated_model) begin
      fails++;
      $display("[TB] FAIL test_stats count: got %0d need %0d", GATED_CNT, gated_model);
    end
    STATS_CLR = 1'b1;
    tick();
    STATS_CLR = 1'b0;
    checks++;
    if (GATED_CNT !== 16'd0) begin
      fails++;
      $display("[TB] FAIL test_stats clear: got %0d need 0", GATED_CNT);
    end
    tick();
    tick();
    checks++;
    if (GATED_CNT !== gated_model) begin
      fails++;
      $display("[TB] FAIL test_stats after clear: got %0d need %0d", GATED_CNT, gated_model);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    fails    = 0;
    RST      = 1'b1;
    REQ      = 1'b0;
    FORCE_ON = 1'b0;
`ifdef CLK_GATE_STATS_EN
    STATS_CLR = 1'b0;
`endif
    $display("[TB] starting clk_gate_ctrl bench");
    test_reset();
    test_wake();
    test_idle_gating();
    test_back_to_back();
    test_force_on();
    test_reset_mid();
`ifdef CLK_GATE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
